alu_sequencer: RTL
==================

# alu_sequencer

Control FSM that sits between the operation button and the 8-bit ALU/two-entry register file (A at address 0, B at address 1). It captures one operation per rising edge of `go`, drives the ALU opcode, and captures the ALU result into `y`. It performs register-file writes through a single write port, including the two-write A/B swap. It reports `busy`/`done` status and keeps a count of completed operations.

## Interface
- `WIDTH`, 8, data width of registers, ALU result and `data`
- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low; low forces reset state immediately
- `go`  in  1  operation request, already synchronized to `clk`; acts on its rising edge
- `opcode`  in  4  operation code; sampled with `go`
- `data`  in  WIDTH  immediate load value; sampled with `go`
- `a_in`  in  WIDTH  register file read port, A
- `b_in`  in  WIDTH  register file read port, B
- `alu_y`  in  WIDTH  combinational ALU result for `alu_op`
- `alu_op`  out  4  opcode presented to the ALU (registered)
- `y`  out  WIDTH  captured result register
- `reg_we`  out  1  register file write enable
- `reg_addr`  out  1  write address (0=A, 1=B)
- `reg_wdata`  out  WIDTH  write data
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle completion pulse
- `op_count`  out  8  completed-operation counter

## Operation
- Reset values: state IDLE; `alu_op`=0, `y`=0, `reg_we`=0, `reg_addr`=0, `reg_wdata`=0, `busy`=0, `done`=0, `op_count`=0. The internal `go_q` (previous `go`) resets to 1, so a `go` already high at reset release does not trigger.
- Trigger: in IDLE with `go`=1 and `go_q`=0, latch `opcode` to `op_q` and `alu_op`, latch `data` to `data_q`, and leave IDLE. `go_q` tracks `go` every cycle in every state. Edges while `busy`=1 are ignored and not queued.
- Routing from IDLE on trigger:
  - opcode 0000–1100 → ISSUE
  - 1101 → WR_Y
  - 1110 → SWAP1
  - 1111 → WR_D
- ISSUE: ALU settles on `alu_op`. Next state EXEC.
- EXEC: `y` <= `alu_y`. Next state DONE.
- WR_Y: `reg_we`=1, `reg_addr`=0, `reg_wdata`=`y`. Next state DONE.
- WR_D: `reg_we`=1, `reg_addr`=0, `reg_wdata`=`data_q`. Next state DONE.
- SWAP1: `tmp` <= `a_in`; `reg_we`=1, `reg_addr`=0, `reg_wdata`=`b_in`. Next state SWAP2.
- SWAP2: `reg_we`=1, `reg_addr`=1, `reg_wdata`=`tmp`. Next state DONE.
- DONE: `done`=1; `op_count` <= `op_count`+1, wrapping 255→0. Next state IDLE.
- `reg_we`, `reg_addr` and `reg_wdata` are decoded from state. `reg_we`=0 in IDLE, ISSUE, EXEC and DONE. `reg_addr` and `reg_wdata` are 0 whenever `reg_we`=0.
- `y` changes only in EXEC. Register-file opcodes leave `y` unchanged.
- Unlisted states recover to IDLE on the next edge.

## Timing
- Edge k samples the trigger; the FSM leaves IDLE at edge k.
- ALU ops: ISSUE in cycle k..k+1, EXEC in k+1..k+2. `y` is valid after edge k+2. `done` is high during k+2..k+3. IDLE after k+3. Total: 3 cycles trigger-to-idle.
- WR_Y / WR_D: write cycle k..k+1, `done` k+1..k+2. Total: 2 cycles.
- Swap: write A in cycle k..k+1, write B in k+1..k+2, `done` k+2..k+3. Total: 3 cycles.
- A new trigger is accepted no earlier than the edge after the cycle in which `done`=1, because the FSM must be back in IDLE.
- Reset asserted mid-operation: all outputs go to reset values asynchronously and any in-flight write is dropped.
  - After SWAP1 has completed and before SWAP2, A holds old B; no rollback.
  - `op_count` is not incremented for the aborted op.

## Test plan
- Reset release with `go`=1 held, then go low → `busy` stays 0 and `op_count`=0. A fresh 0→1 on `go` with opcode 0000, `alu_y`=8'h3C → `y`=8'h3C after edge k+2, `done` pulse, `op_count`=1.
- Swap with A=8'h12, B=8'hA5 → cycle k: write addr 0 data 8'hA5. Cycle k+1: write addr 1 data 8'h12. `done` in k+2. `y` unchanged.
- Opcode 1111, `data`=8'h7E; `data` changed to 8'h00 one cycle after trigger → single write addr 0 data 8'h7E; `busy` high exactly 2 cycles.
- Opcode 1101 after an ALU op leaving `y`=8'h81 → write addr 0 data 8'h81. A second `go` edge while `busy`=1 → ignored, `op_count` increments once.
- 256 back-to-back ops → `op_count` wraps to 0. Reset pulsed low between SWAP1 and SWAP2 → `reg_we` drops immediately, outputs zero, no `done`, `op_count` unchanged.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// Bus between the ALU sequencer and its surroundings: button/op inputs,
// register-file read/write ports, ALU opcode/result and status.
interface alu_sequencer_if #(parameter int WIDTH = 8);
  logic             go;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] alu_y;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] y;
  logic             reg_we;
  logic             reg_addr;
  logic [WIDTH-1:0] reg_wdata;
  logic             busy;
  logic             done;
  logic [7:0]       op_count;

  modport master (
    output go, opcode, data, a_in, b_in, alu_y,
    input  alu_op, y, reg_we, reg_addr, reg_wdata, busy, done, op_count
  );

  modport slave (
    input  go, opcode, data, a_in, b_in, alu_y,
    output alu_op, y, reg_we, reg_addr, reg_wdata, busy, done, op_count
  );
endinterface

// File: rtl/alu_sequencer.sv
// Control FSM for an 8-bit ALU and two-entry register file: one op per go
// rising edge, ALU result capture, single-port writes and a two-cycle A/B swap.
module alu_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  alu_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, EXEC, WR_Y, WR_D, SWAP1, SWAP2, DONE
  } state_t;

  state_t           state, state_nxt;
  logic             go_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] tmp;
  logic             trig;

  // go_q resets high so a button already pressed at reset release is ignored
  assign trig = (state == IDLE) && bus.go && !go_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (trig) begin
        if (bus.opcode <= 4'd12)       state_nxt = ISSUE;
        else if (bus.opcode == 4'd13)  state_nxt = WR_Y;
        else if (bus.opcode == 4'd14)  state_nxt = SWAP1;
        else                           state_nxt = WR_D;
      end
      ISSUE:                state_nxt = EXEC;
      SWAP1:                state_nxt = SWAP2;
      EXEC, WR_Y, WR_D,
      SWAP2:                state_nxt = DONE;
      DONE:                 state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  // Write port is a pure state decode, so reset kills an in-flight write at once
  always_comb begin
    bus.reg_we    = 1'b0;
    bus.reg_addr  = 1'b0;
    bus.reg_wdata = '0;
    bus.busy      = (state != IDLE);
    bus.done      = (state == DONE);
    case (state)
      WR_Y: begin
        bus.reg_we    = 1'b1;
        bus.reg_wdata = bus.y;
      end
      WR_D: begin
        bus.reg_we    = 1'b1;
        bus.reg_wdata = data_q;
      end
      SWAP1: begin
        bus.reg_we    = 1'b1;
        bus.reg_wdata = bus.b_in;
      end
      SWAP2: begin
        bus.reg_we    = 1'b1;
        bus.reg_addr  = 1'b1;
        bus.reg_wdata = tmp;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      go_q         <= 1'b1;
      bus.alu_op   <= '0;
      data_q       <= '0;
      tmp          <= '0;
      bus.y        <= '0;
      bus.op_count <= '0;
    end else begin
      go_q <= bus.go;
      if (trig) begin
        bus.alu_op <= bus.opcode;
        data_q     <= bus.data;
      end
      if (state == EXEC)  bus.y        <= bus.alu_y;
      if (state == SWAP1) tmp          <= bus.a_in;
      if (state == DONE)  bus.op_count <= bus.op_count + 8'd1;
    end
  end

endmodule
